// File: rtl/rob_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rob_pkg
// Purpose  : Shared definitions for the reorder buffer: default geometry,
//            opcode encodings, tag type and the entry record.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package rob_pkg;

  // Default geometry; rob_param takes its parameter defaults from here.
  localparam int ROB_DEPTH   = 8;
  localparam int ROB_XLEN    = 32;
  localparam int ROB_OPW     = 3;
  localparam int ROB_REGW    = 5;
  localparam int ROB_NUM_CDB = 2;

  // Opcode encodings
  localparam logic [2:0] ALU = 3'b001;
  localparam logic [2:0] LD  = 3'b010;
  localparam logic [2:0] ST  = 3'b011;
  localparam logic [2:0] FP  = 3'b100;

  // Tag: an index into the entry array, sized by the depth.
  typedef logic [$clog2(ROB_DEPTH)-1:0] rob_tag_t;

  // One reorder-buffer slot at the default geometry.
  typedef struct packed {
    logic                valid;
    logic                done;
    logic                exception;
    logic [ROB_OPW-1:0]  opcode;
    logic [ROB_REGW-1:0] rs1;
    logic [ROB_REGW-1:0] rs2;
    logic [ROB_REGW-1:0] rd;
    logic [ROB_XLEN-1:0] value;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/rob_wrap_ptr.sv
`default_nettype none
// ============================================================================
// Module   : rob_wrap_ptr
// Purpose  : Circular pointer with an extra wrap bit. The low IDXW bits index
//            the buffer; the top bit toggles on every wrap so equal indices
//            with differing wrap bits mean "full".
// Ports    : clock, reset_n (async active-low)
//            i_inc  advance by one
//            i_clr  return to zero (takes priority over i_inc)
//            o_ptr  {wrap, index}
// Revision : 1.0  initial release
// ============================================================================
module rob_wrap_ptr #(
  parameter int IDXW = 3
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_inc,
  input  logic            i_clr,
  output logic [IDXW:0]   o_ptr
);

  logic [IDXW:0] r_ptr;

  // Depth is a power of two, so plain binary increment wraps the index
  // and toggles the wrap bit at the same time.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ptr <= '0;
    end else if (i_clr) begin
      r_ptr <= '0;
    end else if (i_inc) begin
      r_ptr <= r_ptr + 1'b1;
    end
  end

  assign o_ptr = r_ptr;

endmodule
`default_nettype wire

// File: rtl/rob_param.sv
`default_nettype none
// ============================================================================
// Module   : rob_param
// Purpose  : Parametrised reorder buffer. In-order allocation from dispatch,
//            out-of-order completion from NUM_CDB result buses, in-order
//            retirement over a valid/ready handshake. An exception reaching
//            retirement, or an external flush, empties the buffer.
// Ports    : clock/reset_n        clock, async active-low reset
//            flush                external squash
//            dispatch_*           allocation request, ready and assigned tag
//            cdb_*                per-bus completion (packed, bus 0 in LSBs)
//            retire_*             head entry presentation and handshake
//            exception_flush      one-cycle pulse after an exception retires
//            head/tail/count/full/empty  occupancy status
// Revision : 1.0  initial release
// ============================================================================
module rob_param
  import rob_pkg::*;
#(
  parameter int DEPTH   = ROB_DEPTH,
  parameter int XLEN    = ROB_XLEN,
  parameter int OPW     = ROB_OPW,
  parameter int REGW    = ROB_REGW,
  parameter int NUM_CDB = ROB_NUM_CDB,
  parameter int TW      = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    dispatch_valid,
  output logic                    dispatch_ready,
  input  logic [OPW-1:0]          dispatch_opcode,
  input  logic [REGW-1:0]         dispatch_rs1,
  input  logic [REGW-1:0]         dispatch_rs2,
  input  logic [REGW-1:0]         dispatch_rd,
  output logic [TW-1:0]           dispatch_tag,
  input  logic [NUM_CDB-1:0]      cdb_valid,
  input  logic [NUM_CDB*TW-1:0]   cdb_tag,
  input  logic [NUM_CDB*XLEN-1:0] cdb_value,
  input  logic [NUM_CDB-1:0]      cdb_exception,
  output logic                    retire_valid,
  input  logic                    retire_ready,
  output logic [TW-1:0]           retire_tag,
  output logic [OPW-1:0]          retire_opcode,
  output logic [REGW-1:0]         retire_rd,
  output logic [XLEN-1:0]         retire_value,
  output logic                    retire_exception,
  output logic                    exception_flush,
  output logic [TW-1:0]           head,
  output logic [TW-1:0]           tail,
  output logic [TW:0]             count,
  output logic                    full,
  output logic                    empty
);

  // Entry record at this instance's geometry.
  typedef struct packed {
    logic            valid;
    logic            done;
    logic            exception;
    logic [OPW-1:0]  opcode;
    logic [REGW-1:0] rs1;
    logic [REGW-1:0] rs2;
    logic [REGW-1:0] rd;
    logic [XLEN-1:0] value;
  } entry_t;

  entry_t          r_ent [DEPTH];
  logic [TW:0]     r_count;
  logic            r_exc_flush;

  logic [TW:0]     w_hptr, w_tptr;
  logic [TW-1:0]   w_hidx, w_tidx;
  entry_t          w_head_ent, w_new_ent;
  logic            w_full, w_empty;
  logic            w_disp_fire, w_ret_fire, w_exc_ret, w_clear;
  logic            w_dup_tag;
  logic [TW-1:0]   w_cdb_tag [NUM_CDB];
  logic [XLEN-1:0] w_cdb_val [NUM_CDB];

  for (genvar gb = 0; gb < NUM_CDB; gb++) begin : g_cdb
    assign w_cdb_tag[gb] = cdb_tag[gb*TW +: TW];
    assign w_cdb_val[gb] = cdb_value[gb*XLEN +: XLEN];
  end

  assign w_hidx     = w_hptr[TW-1:0];
  assign w_tidx     = w_tptr[TW-1:0];
  assign w_head_ent = r_ent[w_hidx];
  assign w_full     = (w_hidx == w_tidx) && (w_hptr[TW] != w_tptr[TW]);
  assign w_empty    = (w_hptr == w_tptr);

  // Ready comes from registered state only: a same-cycle retire does not
  // open a slot for dispatch.
  assign w_disp_fire = dispatch_valid && !w_full && !flush;
  assign retire_valid = w_head_ent.valid && w_head_ent.done && !flush;
  assign w_ret_fire  = retire_valid && retire_ready;
  assign w_exc_ret   = w_ret_fire && w_head_ent.exception;
  assign w_clear     = flush || w_exc_ret;

  rob_wrap_ptr #(.IDXW(TW)) u_head_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_ret_fire),
    .i_clr   (w_clear),
    .o_ptr   (w_hptr)
  );

  rob_wrap_ptr #(.IDXW(TW)) u_tail_ptr (
    .clock   (clock),
    .reset_n (reset_n),
    .i_inc   (w_disp_fire),
    .i_clr   (w_clear),
    .o_ptr   (w_tptr)
  );

  always_comb begin
    w_new_ent           = '0;
    w_new_ent.valid     = 1'b1;
    w_new_ent.opcode    = dispatch_opcode;
    w_new_ent.rs1       = dispatch_rs1;
    w_new_ent.rs2       = dispatch_rs2;
    w_new_ent.rd        = dispatch_rd;
  end

  // Write order inside the edge sets precedence: buses are visited from the
  // highest index down so bus 0 lands last and wins a tag collision; the
  // dispatch write comes after completions so an (illegal) collision with a
  // fresh allocation leaves done=0.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else if (w_clear) begin
      for (int i = 0; i < DEPTH; i++) r_ent[i] <= '0;
    end else begin
      for (int b = NUM_CDB - 1; b >= 0; b--) begin
        if (cdb_valid[b] && r_ent[w_cdb_tag[b]].valid) begin
          r_ent[w_cdb_tag[b]].done      <= 1'b1;
          r_ent[w_cdb_tag[b]].value     <= w_cdb_val[b];
          r_ent[w_cdb_tag[b]].exception <= cdb_exception[b];
        end
      end
      if (w_ret_fire)  r_ent[w_hidx].valid <= 1'b0;
      if (w_disp_fire) r_ent[w_tidx]       <= w_new_ent;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count     <= '0;
      r_exc_flush <= 1'b0;
    end else begin
      r_exc_flush <= w_exc_ret;
      if (w_clear) begin
        r_count <= '0;
      end else if (w_disp_fire && !w_ret_fire) begin
        r_count <= r_count + 1'b1;
      end else if (w_ret_fire && !w_disp_fire) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Two buses naming the same tag in one cycle indicates an upstream bug.
  always_comb begin
    w_dup_tag = 1'b0;
    for (int a = 0; a < NUM_CDB; a++) begin
      for (int b = a + 1; b < NUM_CDB; b++) begin
        if (cdb_valid[a] && cdb_valid[b] && (w_cdb_tag[a] == w_cdb_tag[b]))
          w_dup_tag = 1'b1;
      end
    end
  end

  a_no_dup_cdb_tag : assert property (@(posedge clock) disable iff (!reset_n) !w_dup_tag)
    else $error("rob_param: two completion buses carry the same tag");

  assign dispatch_ready   = !w_full;
  assign dispatch_tag     = w_tidx;
  assign retire_tag       = w_hidx;
  assign retire_opcode    = w_head_ent.opcode;
  assign retire_rd        = w_head_ent.rd;
  assign retire_value     = w_head_ent.value;
  assign retire_exception = w_head_ent.exception;
  assign exception_flush  = r_exc_flush;
  assign head             = w_hidx;
  assign tail             = w_tidx;
  assign count            = r_count;
  assign full             = w_full;
  assign empty            = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_rob_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_rob_param
// Purpose  : Self-checking bench for rob_param: directed scenarios followed
//            by random traffic, all compared against a slot-array model.
// Revision : 1.0  initial release
// ============================================================================
module tb_rob_param;
  import rob_pkg::*;

  localparam int DEPTH = 8, XLEN = 32, OPW = 3, REGW = 5, NUM_CDB = 2;
  localparam int TW = $clog2(DEPTH);

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic                    reset_n, flush, dispatch_valid, dispatch_ready;
  logic [OPW-1:0]          dispatch_opcode;
  logic [REGW-1:0]         dispatch_rs1, dispatch_rs2, dispatch_rd;
  logic [TW-1:0]           dispatch_tag;
  logic [NUM_CDB-1:0]      cdb_valid, cdb_exception;
  logic [NUM_CDB*TW-1:0]   cdb_tag;
  logic [NUM_CDB*XLEN-1:0] cdb_value;
  logic                    retire_valid, retire_ready, retire_exception, exception_flush;
  logic [TW-1:0]           retire_tag, head, tail;
  logic [OPW-1:0]          retire_opcode;
  logic [REGW-1:0]         retire_rd;
  logic [XLEN-1:0]         retire_value;
  logic [TW:0]             count;
  logic                    full, empty;

  rob_param #(.DEPTH(DEPTH), .XLEN(XLEN), .OPW(OPW), .REGW(REGW), .NUM_CDB(NUM_CDB)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_opcode(dispatch_opcode), .dispatch_rs1(dispatch_rs1),
    .dispatch_rs2(dispatch_rs2), .dispatch_rd(dispatch_rd), .dispatch_tag(dispatch_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .cdb_exception(cdb_exception),
    .retire_valid(retire_valid), .retire_ready(retire_ready), .retire_tag(retire_tag),
    .retire_opcode(retire_opcode), .retire_rd(retire_rd), .retire_value(retire_value),
    .retire_exception(retire_exception), .exception_flush(exception_flush),
    .head(head), .tail(tail), .count(count), .full(full), .empty(empty)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  // ---------------- reference model: plain slot arrays ----------------
  bit              m_valid [DEPTH];
  bit              m_done  [DEPTH];
  bit              m_exc   [DEPTH];
  logic [OPW-1:0]  m_op    [DEPTH];
  logic [REGW-1:0] m_rd    [DEPTH];
  logic [XLEN-1:0] m_val   [DEPTH];
  int              m_head, m_tail, m_count;
  bit              m_xflush;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 0; m_done[i] = 0; m_exc[i] = 0;
      m_op[i] = '0; m_rd[i] = '0; m_val[i] = '0;
    end
    m_head = 0; m_tail = 0; m_count = 0; m_xflush = 0;
  endtask

  // Applies the inputs currently on the pins to the model at a clock edge.
  task automatic model_update();
    bit dfire, rfire;
    bit claimed [DEPTH];
    int t;
    if (flush) begin
      model_reset();
      return;
    end
    dfire = dispatch_valid && (m_count < DEPTH);
    rfire = m_valid[m_head] && m_done[m_head] && retire_ready;
    if (rfire && m_exc[m_head]) begin
      model_reset();
      m_xflush = 1;
      return;
    end
    for (int i = 0; i < DEPTH; i++) claimed[i] = 0;
    for (int b = 0; b < NUM_CDB; b++) begin
      t = int'(cdb_tag[b*TW +: TW]);
      if (cdb_valid[b] && m_valid[t] && !claimed[t]) begin
        claimed[t] = 1;
        m_done[t]  = 1;
        m_val[t]   = cdb_value[b*XLEN +: XLEN];
        m_exc[t]   = cdb_exception[b];
      end
    end
    if (rfire) begin
      m_valid[m_head] = 0;
      m_head = (m_head + 1) % DEPTH;
    end
    if (dfire) begin
      m_valid[m_tail] = 1; m_done[m_tail] = 0; m_exc[m_tail] = 0;
      m_op[m_tail] = dispatch_opcode; m_rd[m_tail] = dispatch_rd; m_val[m_tail] = '0;
      m_tail = (m_tail + 1) % DEPTH;
    end
    m_count  = m_count + int'(dfire) - int'(rfire);
    m_xflush = 0;
  endtask

  task automatic compare_model();
    int h;
    h = m_head;
    check("dispatch_ready",   dispatch_ready,   m_count < DEPTH);
    check("dispatch_tag",     dispatch_tag,     m_tail);
    check("retire_valid",     retire_valid,     m_valid[h] && m_done[h] && !flush);
    check("retire_tag",       retire_tag,       h);
    check("retire_opcode",    retire_opcode,    m_op[h]);
    check("retire_rd",        retire_rd,        m_rd[h]);
    check("retire_value",     retire_value,     m_val[h]);
    check("retire_exception", retire_exception, m_exc[h]);
    check("head",             head,             m_head);
    check("tail",             tail,             m_tail);
    check("count",            count,            m_count);
    check("full",             full,             m_count == DEPTH);
    check("empty",            empty,            m_count == 0);
    check("exception_flush",  exception_flush,  m_xflush);
  endtask

  // One clock: compare at the falling edge, advance the model at the rising
  // edge, then give the caller a point 1 time unit past the edge to drive.
  task automatic tick();
    @(negedge clock);
    compare_model();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic idle();
    flush = 0; dispatch_valid = 0; dispatch_opcode = '0;
    dispatch_rs1 = '0; dispatch_rs2 = '0; dispatch_rd = '0;
    cdb_valid = '0; cdb_tag = '0; cdb_value = '0; cdb_exception = '0;
    retire_ready = 0;
  endtask

  task automatic set_disp(input logic [OPW-1:0] op, input int rd, input int rs1, input int rs2);
    dispatch_valid = 1; dispatch_opcode = op;
    dispatch_rd = REGW'(rd); dispatch_rs1 = REGW'(rs1); dispatch_rs2 = REGW'(rs2);
  endtask

  task automatic set_cdb(input int b, input int t, input logic [XLEN-1:0] v, input bit ex);
    cdb_valid[b] = 1'b1;
    cdb_tag[b*TW +: TW] = TW'(t);
    cdb_value[b*XLEN +: XLEN] = v;
    cdb_exception[b] = ex;
  endtask

  task automatic drive_random();
    int t0, t1;
    idle();
    flush = ($urandom_range(0, 63) == 0);
    if ($urandom_range(0, 3) != 0)
      set_disp(OPW'($urandom_range(1, 4)), $urandom_range(0, 31), $urandom_range(0, 31),
               $urandom_range(0, 31));
    retire_ready = ($urandom_range(0, 3) != 0);
    t0 = $urandom_range(0, DEPTH - 1);
    t1 = $urandom_range(0, DEPTH - 1);
    if (t1 == t0) t1 = (t0 + 1) % DEPTH;
    if ($urandom_range(0, 1) != 0) set_cdb(0, t0, $urandom, $urandom_range(0, 15) == 0);
    if ($urandom_range(0, 1) != 0) set_cdb(1, t1, $urandom, $urandom_range(0, 15) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    reset_n = 0;
    #12;
    check("rst_head", head, 0);
    check("rst_tail", tail, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ready", dispatch_ready, 1);
    check("rst_retire_valid", retire_valid, 0);
    check("rst_retire_value", retire_value, 0);
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;

    // In-order allocation of three ops
    set_disp(LD, 2, 4, 0); #1 check("tag0", dispatch_tag, 0); tick();
    set_disp(FP, 3, 1, 2); #1 check("tag1", dispatch_tag, 1); tick();
    set_disp(ST, 4, 3, 0); #1 check("tag2", dispatch_tag, 2); tick();
    idle(); #1;
    check("alloc_tail", tail, 3);
    check("alloc_count", count, 3);
    check("alloc_no_retire", retire_valid, 0);

    // Out-of-order completion, then in-order retirement
    set_cdb(0, 1, 7, 0); tick();
    idle(); #1 check("younger_done_blocked", retire_valid, 0);
    set_cdb(1, 0, 5, 0); #1 check("no_cdb_bypass", retire_valid, 0); tick();
    idle(); retire_ready = 1; #1;
    check("head_ready", retire_valid, 1);
    check("head_rd", retire_rd, 2);
    check("head_value", retire_value, 5);
    tick();
    #1 check("second_retire_tag", retire_tag, 1);
    check("second_retire_value", retire_value, 7);
    tick();
    idle(); #1 check("after_retire_head", head, 2);

    // Fill to full, then retire one with dispatch held
    flush = 1; tick();
    idle();
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(ALU, i, 0, 0); tick();
    end
    #1 check("fill_full", full, 1);
    check("fill_ready", dispatch_ready, 0);
    check("fill_tail_wrapped", tail, 0);
    set_cdb(0, 0, 32'h55, 0); tick();
    cdb_valid = '0; retire_ready = 1; #1;
    check("full_retire_valid", retire_valid, 1);
    tick();
    retire_ready = 0; #1;
    check("no_bypass_tail", tail, 0);
    check("no_bypass_count", count, DEPTH - 1);
    tick();
    #1 check("ninth_tail", tail, 1);
    check("ninth_full", full, 1);

    // Exception retirement clears the buffer
    idle(); flush = 1; tick();
    idle(); set_disp(LD, 6, 1, 1); tick();
    set_disp(ALU, 7, 2, 2); tick();
    idle(); set_cdb(0, 0, 11, 0); set_cdb(1, 1, 22, 1); tick();
    idle(); retire_ready = 1; #1 check("exc_first_tag", retire_tag, 0); tick();
    set_disp(ST, 9, 0, 0); #1 check("exc_head_exception", retire_exception, 1); tick();
    idle(); #1;
    check("exc_count", count, 0);
    check("exc_head", head, 0);
    check("exc_tail", tail, 0);
    check("exc_pulse", exception_flush, 1);
    tick();
    #1 check("exc_pulse_end", exception_flush, 0);

    // External flush with a completion and a ready head in flight
    for (int i = 0; i < 4; i++) begin
      set_disp(ALU, i, 0, 0); tick();
    end
    idle(); set_cdb(0, 0, 99, 0); tick();
    idle(); retire_ready = 1; flush = 1; set_cdb(1, 2, 123, 0);
    #1 check("flush_masks_retire", retire_valid, 0);
    tick();
    idle(); #1;
    check("flush_empty", empty, 1);
    check("flush_count", count, 0);
    check("flush_no_exc_pulse", exception_flush, 0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      drive_random();
      tick();
    end

    // Asynchronous reset between clock edges
    idle(); for (int i = 0; i < 3; i++) begin set_disp(FP, i, 0, 0); tick(); end
    idle(); #2;
    reset_n = 0;
    #1;
    check("async_rst_count", count, 0);
    check("async_rst_tail", tail, 0);
    check("async_rst_empty", empty, 1);
    check("async_rst_retire_valid", retire_valid, 0);
    model_reset();
    @(negedge clock); reset_n = 1;
    @(posedge clock); #1;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rob_param.md
Name: rob_param

Overview:
Parametrised reorder buffer for the out-of-order core, succeeding the fixed 8-entry ROB. It allocates entries in program order from dispatch and accepts out-of-order results from NUM_CDB completion buses. It retires in order through a valid/ready handshake. A retiring exception entry, or an external flush, clears the buffer.

Parameters:
DEPTH, 8, entry count; power of two, >= 2
XLEN, 32, result value width
OPW, 3, opcode width
REGW, 5, architectural register index width
NUM_CDB, 2, number of completion buses

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  external squash; clears all entries
dispatch_valid  in  1  dispatch request
dispatch_ready  out  1  entry available (= !full)
dispatch_opcode  in  OPW  opcode
dispatch_rs1  in  REGW  source reg 1
dispatch_rs2  in  REGW  source reg 2
dispatch_rd  in  REGW  destination reg
dispatch_tag  out  log2(DEPTH)  tag allocated on this dispatch (= tail index)
cdb_valid  in  NUM_CDB  per-bus completion strobe
cdb_tag  in  NUM_CDB x log2(DEPTH)  completing entry
cdb_value  in  NUM_CDB x XLEN  result
cdb_exception  in  NUM_CDB  completing op faulted
retire_valid  out  1  head entry valid and done
retire_ready  in  1  consumer accepts retirement
retire_tag  out  log2(DEPTH)  head index
retire_opcode  out  OPW  head opcode
retire_rd  out  REGW  head destination
retire_value  out  XLEN  head value
retire_exception  out  1  head faulted
exception_flush  out  1  registered one-cycle pulse after an exception entry retires
head  out  log2(DEPTH)  head index
tail  out  log2(DEPTH)  tail index
count  out  log2(DEPTH)+1  occupied entries
full  out  1  count == DEPTH
empty  out  1  count == 0

Behaviour:
- Reset (async, reset_n low): all entries invalid and zeroed; head=tail=0; count=0; empty=1; full=0; dispatch_ready=1; retire_valid=0; exception_flush=0; all retire_* fields 0.
- Pointers: log2(DEPTH)+1 bits with a wrap bit. Full means index bits equal and wrap bits differ. Empty means the pointers are equal. Indices wrap DEPTH-1 -> 0.
- Dispatch fires when dispatch_valid && dispatch_ready && !flush.
  - At that edge, entry[tail] is written with opcode/rs1/rs2/rd, valid=1, done=0, value=0, exception=0; tail advances.
  - dispatch_tag shows the pre-increment tail combinationally.
- dispatch_ready depends on registered state only. When full, dispatch is refused even if a retire fires in the same cycle; there is no bypass.
- Completion: for each bus with cdb_valid=1 whose tag addresses a valid entry, set done=1 and write value and exception at the edge.
  - A completion to an invalid entry is ignored.
  - If two buses carry the same tag in one cycle, the lower bus index wins; a simulation assertion flags this as an error.
- Retire: retire_valid = valid[head] && done[head] && !flush. retire_* fields are driven combinationally from entry[head].
  - Retire fires when retire_valid && retire_ready. Entry[head] is invalidated and head advances.
  - A completion to the head entry is visible to retire one cycle later; there is no CDB-to-retire bypass.
- count is the registered occupancy: +1 on dispatch fire, -1 on retire fire, unchanged when both fire.
- Exception retire: when retire fires with retire_exception=1, all entries are invalidated at that same edge, head=tail=0, count=0, and exception_flush is high for exactly the next cycle. A dispatch in that cycle is dropped.
- External flush has priority over everything in its cycle:
  - No dispatch, completion or retire takes effect.
  - Next state equals the reset state; exception_flush stays 0.
- Reset asserted mid-operation aborts immediately to the reset state; no partial writes survive.
- Simultaneous dispatch plus completion on the same index cannot be legal, because tags are only issued to invalid slots. If it occurs anyway, dispatch wins: done=0.

Decomposition:
- rob_pkg holds:
  - opcode constants ALU=3'b001, LD=3'b010, ST=3'b011, FP=3'b100
  - rob_entry_t struct {valid, done, exception, opcode, rs1, rs2, rd, value}
  - the tag typedef parametrised by DEPTH
- One sub-module, rob_wrap_ptr: a wrap-bit pointer register with inc and clear inputs, instantiated for head and tail.

Test Plan:
- Reset -> head=0, tail=0, count=0, empty=1, full=0, dispatch_ready=1, retire_valid=0.
- Dispatch LD rd=f1(2) rs1=r1(4), FP rd=f2(3) rs1=f0(1) rs2=f1(2), ST rs1=f2(3) rd=r1(4) on consecutive cycles.
  - Tags 0,1,2; tail=3; count=3; retire_valid=0.
- CDB0 completes tag 1 value 7 while tag 0 is still pending -> retire_valid=0.
  - Then CDB1 completes tag 0 value 5 -> next cycle retire_valid=1, retire_rd=2, retire_value=5.
  - With retire_ready=1, tags 0 then 1 retire in order.
- Dispatch 8 ops -> full=1, dispatch_ready=0.
  - Retire 1 with dispatch_valid held -> new entry allocated only the cycle after.
  - After 9 dispatches total, tail has wrapped from 7 to 0 and then to 1.
- Complete tag 1 with cdb_exception=1 and retire tags 0 and 1 -> count=0, head=tail=0 at the edge of tag 1's retirement.
  - exception_flush=1 for exactly one cycle.
- Assert flush with 4 valid entries and an active CDB write -> next cycle empty=1, count=0, no retire occurred.
- Pull reset_n low mid-stream -> outputs return to reset values without waiting for a clock edge.
